// File: rtl/fir_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_rr_sched_if
// Description : Bundle of the per-channel sample handshake, the flush pulse,
//               the tagged result handshake and the busy flag of the
//               round-robin FIR scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_rr_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int DW  = 8,
  parameter int OW  = 10
);
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              flush;
  logic              out_valid;
  logic [OW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_ready;
  logic              busy;

  // Producer/consumer side: drives samples, flush and result acceptance.
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ch, busy
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_ch, busy
  );
endinterface
`default_nettype wire

// File: rtl/fir_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : fir_rr_sched
// Description : Shares one 5-tap shift-add FIR datapath among NCH sample
//               streams. Streams are granted round-robin; each keeps its own
//               4-sample history. Results leave tagged with their channel.
//               y = x>>5 + h0>>4 + h1>>3 + h2>>2 + h3>>1   (h0 newest)
// Revision    : 1.0 - initial release
// ============================================================================
module fir_rr_sched #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int DW  = 8,
  parameter int OW  = 10
) (
  input  logic           clk,
  input  logic           rst,
  fir_rr_sched_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    rr_ptr;     // channel with highest priority next grant
  logic [DW-1:0]    x_reg;      // sample captured at accept
  logic [CW-1:0]    ch_reg;     // channel captured at accept
  logic [OW-1:0]    res_data;   // registered result
  logic [CW-1:0]    res_ch;     // registered result tag

  // Arbitration
  logic             grant_found;
  logic [CW-1:0]    grant_ch;
  logic [CW-1:0]    cand;
  logic             accept;
  logic [DW-1:0]    sel_data;

  // Datapath
  logic [4*DW-1:0]  hist_of [NCH];  // {h3,h2,h1,h0} per channel
  logic [4*DW-1:0]  cur_hist;
  logic [DW-1:0]    h0, h1, h2, h3;
  logic [OW-1:0]    y;

  // --------------------------------------------------------------------------
  // Round-robin search: scan offsets from the highest down so that the
  // smallest offset from rr_ptr with a valid request is the one left standing.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = rr_ptr + CW'(i);
      if (bus.in_valid[cand]) begin
        grant_found = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  // Flush outranks any grant; nothing is accepted outside IDLE or in reset.
  assign accept   = (state == IDLE) && !bus.flush && grant_found && !rst;
  assign sel_data = bus.in_data[grant_ch*DW +: DW];

  // One-hot accept strobe towards the granted channel.
  always_comb begin
    bus.in_ready = '0;
    if (accept) begin
      bus.in_ready = NCH'(1) << grant_ch;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel delay lines. Only the channel being computed shifts; a flush
  // in IDLE clears every channel at once.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NCH; k++) begin : g_hist
      logic [DW-1:0] t0, t1, t2, t3;
      logic          shift_en;

      assign shift_en = (state == CALC) && (ch_reg == CW'(k));

      // Hold, clear on flush, or shift in the current sample.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          t0 <= '0;
          t1 <= '0;
          t2 <= '0;
          t3 <= '0;
        end else if ((state == IDLE) && bus.flush) begin
          t0 <= '0;
          t1 <= '0;
          t2 <= '0;
          t3 <= '0;
        end else if (shift_en) begin
          t3 <= t2;
          t2 <= t1;
          t1 <= t0;
          t0 <= x_reg;
        end
      end

      assign hist_of[k] = {t3, t2, t1, t0};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Shared FIR datapath: each tap is a truncating logical shift of the 8-bit
  // value, zero-extended before the unsigned sum (max 243, fits in OW).
  // --------------------------------------------------------------------------
  assign cur_hist = hist_of[ch_reg];
  assign h0       = cur_hist[0*DW +: DW];
  assign h1       = cur_hist[1*DW +: DW];
  assign h2       = cur_hist[2*DW +: DW];
  assign h3       = cur_hist[3*DW +: DW];

  assign y = OW'(x_reg >> 5) + OW'(h0 >> 4) + OW'(h1 >> 3)
           + OW'(h2 >> 2) + OW'(h3 >> 1);

  // --------------------------------------------------------------------------
  // Control FSM and result registers: IDLE grants, CALC registers the sum,
  // OUT holds the result until the downstream takes it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      x_reg    <= '0;
      ch_reg   <= '0;
      res_data <= '0;
      res_ch   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_reg  <= sel_data;
            ch_reg <= grant_ch;
            state  <= CALC;
          end
        end
        CALC: begin
          res_data <= y;
          res_ch   <= ch_reg;
          state    <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            // The channel just served drops to lowest priority.
            rr_ptr <= res_ch + CW'(1);
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status and result outputs; out_valid follows state so reset kills it
  // immediately.
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = res_data;
  assign bus.out_ch    = res_ch;
  assign bus.busy      = (state != IDLE);

endmodule
`default_nettype wire
